// File: rtl/mem_port_initiator_pkg.sv
// Shared defaults for the memory port initiator and its response FIFO.
package mem_port_initiator_pkg;

  localparam int unsigned DEF_ADDR_W          = 12;
  localparam int unsigned DEF_DATA_W          = 16;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;

  // Width of a counter that must hold 0..n inclusive (n a power of two).
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// In-order synchronous FIFO; registered head, no bypass, push-on-full allowed with a same-edge pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_full;
  logic             w_push_en;
  logic             w_pop_en;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == (PTR_W + 1)'(DEPTH));
  assign w_pop_en  = i_pop & ~o_empty;
  assign w_push_en = i_push & (~w_full | w_pop_en);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_initiator.sv
// Credit-limited initiator for one port of a shared memory: registered request stage,
// in-flight tracking, and an in-order response FIFO.
module mem_port_initiator
  import mem_port_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic [DATA_W-1:0]                cmd_wdata,
  input  logic                             cmd_wen,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [DATA_W-1:0]                resp_rdata,
  output logic [ADDR_W-1:0]                port_addr,
  output logic [DATA_W-1:0]                port_data_in,
  output logic                             port_wen,
  output logic                             port_valid_in,
  input  logic [DATA_W-1:0]                port_data_out,
  input  logic                             port_valid_out,
  input  logic                             freeze_inputs,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err_unexpected_resp
);

  localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

  logic              r_port_valid;
  logic              r_port_wen;
  logic [ADDR_W-1:0] r_port_addr;
  logic [DATA_W-1:0] r_port_data;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_inflight;
  logic              r_err;

  logic              w_cmd_hs;
  logic              w_rd_hs;
  logic              w_mem_acc;
  logic              w_rd_acc;
  logic              w_resp_ok;
  logic              w_resp_pop;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_outstanding_d;
  logic [CNT_W-1:0]  w_inflight_d;

  assign cmd_ready  = (~r_port_valid | ~freeze_inputs) &
                      (r_outstanding < CNT_W'(MAX_OUTSTANDING));
  assign w_cmd_hs   = cmd_valid & cmd_ready;
  assign w_rd_hs    = w_cmd_hs & ~cmd_wen;
  assign w_mem_acc  = r_port_valid & ~freeze_inputs;
  assign w_rd_acc   = w_mem_acc & ~r_port_wen;
  // A response only counts against reads already in flight, not one accepted on this edge.
  assign w_resp_ok  = port_valid_out & (r_inflight != '0);
  assign w_resp_pop = resp_valid & resp_ready;

  assign port_valid_in       = r_port_valid;
  assign port_wen            = r_port_wen;
  assign port_addr           = r_port_addr;
  assign port_data_in        = r_port_data;
  assign outstanding         = r_outstanding;
  assign err_unexpected_resp = r_err;
  assign resp_valid          = ~w_fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_port_valid <= 1'b0;
      r_port_wen   <= 1'b0;
      r_port_addr  <= '0;
      r_port_data  <= '0;
    end else if (w_cmd_hs) begin
      r_port_valid <= 1'b1;
      r_port_wen   <= cmd_wen;
      r_port_addr  <= cmd_addr;
      r_port_data  <= cmd_wdata;
    end else if (w_mem_acc) begin
      r_port_valid <= 1'b0;
    end
  end

  always_comb begin
    w_outstanding_d = r_outstanding;
    if (w_rd_hs && !w_resp_pop) begin
      w_outstanding_d = r_outstanding + CNT_W'(1);
    end else if (!w_rd_hs && w_resp_pop) begin
      w_outstanding_d = r_outstanding - CNT_W'(1);
    end
  end

  always_comb begin
    w_inflight_d = r_inflight;
    if (w_rd_acc && !w_resp_ok) begin
      w_inflight_d = r_inflight + CNT_W'(1);
    end else if (!w_rd_acc && w_resp_ok) begin
      w_inflight_d = r_inflight - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
      r_inflight    <= '0;
      r_err         <= 1'b0;
    end else begin
      r_outstanding <= w_outstanding_d;
      r_inflight    <= w_inflight_d;
      if (port_valid_out && !w_resp_ok) r_err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_resp_ok),
    .i_data  (port_data_out),
    .i_pop   (w_resp_pop),
    .o_data  (resp_rdata),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_mem_port_initiator.sv
// Directed and random bench for mem_port_initiator with a fixed-latency memory model
// and an in-order read-data scoreboard.
module tb_mem_port_initiator;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_wen;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic [11:0] port_addr;
  logic [15:0] port_data_in;
  logic        port_wen;
  logic        port_valid_in;
  logic [15:0] port_data_out;
  logic        port_valid_out;
  logic        freeze_inputs;
  logic [2:0]  outstanding;
  logic        err_unexpected_resp;

  typedef struct {
    logic [15:0] data;
    int          due;
  } pend_t;

  logic [15:0] mem_arr [4096];
  logic [15:0] shadow  [4096];
  logic [15:0] exp_q [$];
  pend_t       pend_q [$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          acc_all = 0;
  int          acc_reads = 0;
  int          inject_seq = 0;
  int          inject_seen = 0;
  bit          rand_mode = 1'b0;

  mem_port_initiator #(
    .ADDR_W          (12),
    .DATA_W          (16),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_addr            (cmd_addr),
    .cmd_wdata           (cmd_wdata),
    .cmd_wen             (cmd_wen),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_rdata          (resp_rdata),
    .port_addr           (port_addr),
    .port_data_in        (port_data_in),
    .port_wen            (port_wen),
    .port_valid_in       (port_valid_in),
    .port_data_out       (port_data_out),
    .port_valid_out      (port_valid_out),
    .freeze_inputs       (freeze_inputs),
    .outstanding         (outstanding),
    .err_unexpected_resp (err_unexpected_resp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int a);
    return 16'(a * 7 + 16'h1000);
  endfunction

  // Memory model and scoreboard both act on values settled at the falling edge.
  initial begin : mem_model
    logic [15:0] e;
    for (int a = 0; a < 4096; a++) begin
      mem_arr[a] = init_word(a);
      shadow[a]  = init_word(a);
    end
    port_valid_out = 1'b0;
    port_data_out  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        exp_q.delete();
      end else begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_wen) shadow[cmd_addr] = cmd_wdata;
          else exp_q.push_back(shadow[cmd_addr]);
        end
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check_eq("resp_data", 32'(resp_rdata), 32'(e));
          end
        end
      end
      if (port_valid_in && !freeze_inputs) begin
        acc_all++;
        if (port_wen) begin
          mem_arr[port_addr] = port_data_in;
        end else begin
          acc_reads++;
          pend_q.push_back('{data: mem_arr[port_addr], due: cyc + LAT});
        end
      end
      if (inject_seq != inject_seen) begin
        inject_seen    = inject_seq;
        port_valid_out = 1'b1;
        port_data_out  = 16'hDEAD;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        port_valid_out = 1'b1;
        port_data_out  = pend_q[0].data;
        void'(pend_q.pop_front());
      end else begin
        port_valid_out = 1'b0;
        port_data_out  = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      freeze_inputs = ($urandom_range(0, 3) == 0);
      resp_ready    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input logic wen, input logic [11:0] addr, input logic [15:0] data);
    bit hs = 1'b0;
    cmd_valid = 1'b1;
    cmd_wen   = wen;
    cmd_addr  = addr;
    cmd_wdata = data;
    for (int i = 0; i < 100 && !hs; i++) begin
      #1;
      hs = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!hs) check_eq("cmd_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    rand_mode     = 1'b0;
    resp_ready    = 1'b1;
    freeze_inputs = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (outstanding == 0 && !resp_valid && pend_q.size() == 0 && !port_valid_in) break;
      tick();
    end
    check_eq(tag, 32'(outstanding), 0);
    check_eq({tag, "_sb"}, exp_q.size(), 0);
    resp_ready = 1'b0;
  endtask

  initial begin : stim
    int c0;
    int a0;
    logic [11:0] h_addr;
    logic [15:0] h_data;
    logic        h_wen;

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_wen = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    resp_ready = 1'b0;
    freeze_inputs = 1'b0;
    tick();
    check_eq("rst_cmd_ready", 32'(cmd_ready), 1);
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_port_valid", 32'(port_valid_in), 0);
    check_eq("rst_outstanding", 32'(outstanding), 0);
    check_eq("rst_resp_valid", 32'(resp_valid), 0);
    check_eq("rst_err", 32'(err_unexpected_resp), 0);
    check_eq("rst_cmd_ready_after", 32'(cmd_ready), 1);

    // Single write
    send(1'b1, 12'h005, 16'hBEEF);
    check_eq("wr_port_valid", 32'(port_valid_in), 1);
    check_eq("wr_port_wen", 32'(port_wen), 1);
    check_eq("wr_port_addr", 32'(port_addr), 32'h005);
    check_eq("wr_port_data", 32'(port_data_in), 32'hBEEF);
    check_eq("wr_outstanding", 32'(outstanding), 0);
    tick();
    check_eq("wr_port_idle", 32'(port_valid_in), 0);

    // Read back
    send(1'b0, 12'h005, 16'h0);
    check_eq("rd_outstanding_1", 32'(outstanding), 1);
    check_eq("rd_port_wen", 32'(port_wen), 0);
    for (int i = 0; i < 10 && !resp_valid; i++) tick();
    check_eq("rd_resp_valid", 32'(resp_valid), 1);
    check_eq("rd_resp_data", 32'(resp_rdata), 32'hBEEF);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_eq("rd_outstanding_0", 32'(outstanding), 0);
    check_eq("rd_resp_empty", 32'(resp_valid), 0);

    // Credit limit, back-to-back issue
    a0 = acc_reads;
    c0 = cyc;
    for (int k = 0; k < 4; k++) send(1'b0, 12'(12'h010 + k), 16'h0);
    check_eq("b2b_cycles", 32'(cyc - c0), 4);
    check_eq("cr_outstanding", 32'(outstanding), 4);
    cmd_valid = 1'b1;
    cmd_wen   = 1'b0;
    cmd_addr  = 12'h014;
    #1;
    check_eq("cr_cmd_ready", 32'(cmd_ready), 0);
    for (int i = 0; i < 6; i++) tick();
    check_eq("cr_cmd_ready_held", 32'(cmd_ready), 0);
    check_eq("cr_reads_issued", 32'(acc_reads - a0), 4);
    check_eq("cr_port_idle", 32'(port_valid_in), 0);
    check_eq("cr_resp_valid", 32'(resp_valid), 1);
    cmd_valid = 1'b0;
    drain("cr_drain");

    // Freeze mid-stream
    resp_ready = 1'b1;
    a0 = acc_all;
    send(1'b0, 12'h020, 16'h0);
    freeze_inputs = 1'b1;
    cmd_valid = 1'b1;
    cmd_wen   = 1'b1;
    cmd_addr  = 12'h021;
    cmd_wdata = 16'h1234;
    #1;
    h_addr = port_addr;
    h_data = port_data_in;
    h_wen  = port_wen;
    check_eq("frz_valid", 32'(port_valid_in), 1);
    check_eq("frz_addr_init", 32'(h_addr), 32'h020);
    for (int i = 0; i < 5; i++) begin
      check_eq("frz_cmd_ready", 32'(cmd_ready), 0);
      tick();
      check_eq("frz_hold_valid", 32'(port_valid_in), 1);
      check_eq("frz_hold_addr", 32'(port_addr), 32'(h_addr));
      check_eq("frz_hold_data", 32'(port_data_in), 32'(h_data));
      check_eq("frz_hold_wen", 32'(port_wen), 32'(h_wen));
    end
    check_eq("frz_no_accept", 32'(acc_all - a0), 0);
    freeze_inputs = 1'b0;
    send(1'b1, 12'h021, 16'h1234);
    send(1'b0, 12'h021, 16'h0);
    drain("frz_drain");
    check_eq("frz_accept_count", 32'(acc_all - a0), 3);

    // Unexpected response
    inject_seq++;
    tick();
    tick();
    check_eq("unexp_err", 32'(err_unexpected_resp), 1);
    check_eq("unexp_resp_valid", 32'(resp_valid), 0);
    for (int i = 0; i < 3; i++) tick();
    check_eq("unexp_err_sticky", 32'(err_unexpected_resp), 1);
    check_eq("unexp_resp_valid_hold", 32'(resp_valid), 0);
    check_eq("unexp_outstanding", 32'(outstanding), 0);

    // Random burst with random freeze and pop
    rand_mode = 1'b1;
    for (int k = 0; k < 24; k++) begin
      send(1'($urandom_range(0, 1)), 12'(12'h030 + $urandom_range(0, 7)), 16'($urandom));
    end
    drain("rnd_drain");

    // Reset with reads in flight
    resp_ready = 1'b0;
    send(1'b0, 12'h040, 16'h0);
    send(1'b0, 12'h041, 16'h0);
    tick();
    check_eq("mid_outstanding", 32'(outstanding), 2);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    tick();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_outstanding", 32'(outstanding), 0);
    check_eq("mid_rst_resp_valid", 32'(resp_valid), 0);
    check_eq("mid_rst_port_valid", 32'(port_valid_in), 0);
    check_eq("mid_rst_err", 32'(err_unexpected_resp), 0);
    for (int i = 0; i < 6; i++) tick();
    check_eq("post_rst_err", 32'(err_unexpected_resp), 1);
    check_eq("post_rst_resp_valid", 32'(resp_valid), 0);
    check_eq("post_rst_outstanding", 32'(outstanding), 0);
    check_eq("post_rst_cmd_ready", 32'(cmd_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
